// File: rtl/shift_reg_piso.sv
// Parallel-in / serial-out shift register with a valid/ready load handshake.
// A word is accepted in IDLE or on its predecessor's last-bit cycle, so words can be sent back-to-back.
module shift_reg_piso #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] din,
   output logic             load_ready,
   output logic             out,
   output logic             out_valid,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sr, sr_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             load;

   // Outputs come from registered state only; load_valid and din feed the next-state logic alone.
   assign load_ready = (state == IDLE) || (cnt == '0);
   assign out_valid  = (state == SHIFT);
   assign last       = (state == SHIFT) && (cnt == '0);
   assign out        = (state == SHIFT) && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
   assign load       = load_valid && load_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
      state_next = state;
      sr_next    = sr;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (load) begin
               state_next = SHIFT;
               sr_next    = din;
               cnt_next   = CW'(WIDTH - 1);
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               sr_next  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
               cnt_next = cnt - CW'(1);
            end else if (load) begin
               sr_next  = din;
               cnt_next = CW'(WIDTH - 1);
            end else begin
               state_next = IDLE;
               sr_next    = '0;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            sr_next    = '0;
            cnt_next   = '0;
         end
      endcase
   end

   // NOTE: the async reset clears every register, so a word in flight is dropped at once, not at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking updates so all registers sample the same pre-edge values.
         state <= state_next;
         sr    <= sr_next;
         cnt   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_shift_reg_piso.sv
// Bench for shift_reg_piso: an MSB-first and an LSB-first instance share one stimulus stream.
// A bit-queue model is compared on every falling edge; directed literal checks pin the model.
module tb_shift_reg_piso;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] din;

   logic m_ready, m_out, m_valid, m_last;
   logic l_ready, l_out, l_valid, l_last;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit b;
      bit l;
   } sbit_t;

   sbit_t qm[$];
   sbit_t ql[$];

   shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .din       (din),
      .load_ready(m_ready),
      .out       (m_out),
      .out_valid (m_valid),
      .last      (m_last)
   );

   shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .din       (din),
      .load_ready(l_ready),
      .out       (l_out),
      .out_valid (l_valid),
      .last      (l_last)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: {out,valid,last,ready} got %b want %b", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] msb_now();
      return {m_out, m_valid, m_last, m_ready};
   endfunction

   function automatic logic [3:0] lsb_now();
      return {l_out, l_valid, l_last, l_ready};
   endfunction

   // Model: a word accepted at an edge becomes W queued bits; one bit leaves per edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         qm.delete();
         ql.delete();
      end else if (load_valid && qm.size() <= 1) begin
         if (qm.size() > 0) void'(qm.pop_front());
         if (ql.size() > 0) void'(ql.pop_front());
         for (int i = 0; i < W; i++) begin
            qm.push_back('{b: din[W-1-i], l: (i == W-1)});
            ql.push_back('{b: din[i],     l: (i == W-1)});
         end
      end else begin
         if (qm.size() > 0) void'(qm.pop_front());
         if (ql.size() > 0) void'(ql.pop_front());
      end
   end

   function automatic logic [3:0] model_exp(input sbit_t q[$]);
      if (q.size() == 0) return 4'b0001;
      return {q[0].b, 1'b1, q[0].l, (q.size() <= 1)};
   endfunction

   always @(negedge clk) begin
      chk("model_msb", msb_now(), model_exp(qm));
      chk("model_lsb", lsb_now(), model_exp(ql));
   end

   initial begin
      logic [W-1:0] stream [8];
      stream = '{4'b0101, 4'b1110, 4'b0001, 4'b1011, 4'b0111, 4'b1000, 4'b0010, 4'b1100};

      reset      = 1'b0;
      load_valid = 1'b0;
      din        = '0;

      // Reset held across a rising edge
      #10 chk("rst_t10", msb_now(), 4'b0001);
      #50 chk("rst_t60", msb_now(), 4'b0001);
      #30 chk("rst_t90_lsb", lsb_now(), 4'b0001);
      #10 reset = 1'b1;
      @(negedge clk) chk("idle_after_rst", msb_now(), 4'b0001);

      // Single word 1001, MSB first; din changes after capture
      load_valid = 1'b1; din = 4'b1001;
      @(negedge clk) load_valid = 1'b0; din = 4'b0110;
      chk("single_b1", msb_now(), 4'b1100);
      @(negedge clk) chk("single_b2", msb_now(), 4'b0100);
      @(negedge clk) chk("single_b3", msb_now(), 4'b0100);
      @(negedge clk) chk("single_b4", msb_now(), 4'b1111);
      @(negedge clk) chk("single_idle", msb_now(), 4'b0001);

      // Back-to-back: 1010 held, then 0110 offered on the last-bit edge
      load_valid = 1'b1; din = 4'b1010;
      @(negedge clk) chk("b2b_b1", msb_now(), 4'b1100);
      @(negedge clk) chk("b2b_b2", msb_now(), 4'b0100);
      @(negedge clk) chk("b2b_b3", msb_now(), 4'b1100);
      @(negedge clk) din = 4'b0110;
      chk("b2b_b4", msb_now(), 4'b0111);
      @(negedge clk) load_valid = 1'b0;
      chk("b2b_b5", msb_now(), 4'b0100);
      @(negedge clk) chk("b2b_b6", msb_now(), 4'b1100);
      @(negedge clk) chk("b2b_b7", msb_now(), 4'b1100);
      @(negedge clk) chk("b2b_b8", msb_now(), 4'b0111);
      @(negedge clk) chk("b2b_idle", msb_now(), 4'b0001);

      // Load offered while busy is ignored
      load_valid = 1'b1; din = 4'b1001;
      @(negedge clk) load_valid = 1'b0;
      chk("busy_b1", msb_now(), 4'b1100);
      @(negedge clk) load_valid = 1'b1; din = 4'b1111;
      chk("busy_b2", msb_now(), 4'b0100);
      @(negedge clk) load_valid = 1'b0;
      chk("busy_b3", msb_now(), 4'b0100);
      @(negedge clk) chk("busy_b4", msb_now(), 4'b1111);
      @(negedge clk) chk("busy_idle", msb_now(), 4'b0001);

      // Reset mid-word aborts at once; next word has no remnant
      load_valid = 1'b1; din = 4'b1100;
      @(negedge clk) load_valid = 1'b0;
      chk("abort_b1", msb_now(), 4'b1100);
      @(posedge clk) #30 reset = 1'b0;
      #1 chk("abort_now_msb", msb_now(), 4'b0001);
      chk("abort_now_lsb", lsb_now(), 4'b0001);
      @(negedge clk) reset = 1'b1;
      load_valid = 1'b1; din = 4'b0011;
      @(negedge clk) load_valid = 1'b0;
      chk("rel_b1", msb_now(), 4'b0100);
      @(negedge clk) chk("rel_b2", msb_now(), 4'b0100);
      @(negedge clk) chk("rel_b3", msb_now(), 4'b1100);
      @(negedge clk) chk("rel_b4", msb_now(), 4'b1111);
      @(negedge clk) chk("rel_idle", msb_now(), 4'b0001);

      // LSB-first instance: 1101 -> 1,0,1,1
      load_valid = 1'b1; din = 4'b1101;
      @(negedge clk) load_valid = 1'b0;
      chk("lsb_b1", lsb_now(), 4'b1100);
      @(negedge clk) chk("lsb_b2", lsb_now(), 4'b0100);
      @(negedge clk) chk("lsb_b3", lsb_now(), 4'b1100);
      @(negedge clk) chk("lsb_b4", lsb_now(), 4'b1111);
      @(negedge clk) chk("lsb_idle", lsb_now(), 4'b0001);

      // Continuous offer with din changing every cycle; the model decides which words land
      load_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         din = stream[i % 8];
         @(negedge clk);
      end
      load_valid = 1'b0;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_reg_piso.md
SHIFT_REG_PISO -- requirements
Module: shift_reg_piso

Interface
REQ-001 Parameter WIDTH, default 4, number of bits per parallel word (legal range 2-16).
REQ-002 Parameter MSB_FIRST, default 1, serial bit order (1: din[WIDTH-1] first; 0: din[0] first).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low: reset=0 forces reset state immediately, independent of clk.
REQ-005 load_valid  input  1  parallel word on din is offered for transmission.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 load_ready  output  1  block can accept din at the next rising edge.
REQ-008 out  output  1  serial data bit.
REQ-009 out_valid  output  1  out carries a valid data bit this cycle.
REQ-010 last  output  1  current out bit is the final bit of the word.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-012 A load SHALL occur at a rising edge where load_valid=1 and load_ready=1; din is captured into an internal WIDTH-bit shift register and the bit counter is set to WIDTH-1.
REQ-013 IDLE: load_ready=1, out=0, out_valid=0, last=0; a load transitions to SHIFT; otherwise remain IDLE.
REQ-014 SHIFT: out_valid=1; out SHALL be the shift-register bit selected by MSB_FIRST; last=1 exactly when counter=0.
REQ-015 Latency: word captured at edge k SHALL present bit 0 of the serial sequence in the cycle after edge k and the final bit in the cycle after edge k+WIDTH-1; one bit per clock, no gaps.
REQ-016 In SHIFT with counter>0, each rising edge SHALL shift the register by one position toward the output end (zero fill) and decrement the counter.
REQ-017 load_ready SHALL be 0 in SHIFT while counter>0 and 1 in SHIFT when counter=0 (last-bit cycle).
REQ-018 At the last-bit edge with a load: reload register, counter=WIDTH-1, stay SHIFT; serial stream continues with no idle cycle (back-to-back).
REQ-019 At the last-bit edge without a load: go to IDLE, clear shift register and counter.
REQ-020 load_valid while load_ready=0 SHALL be ignored: no capture, no state change, no error indication.
REQ-021 Changes on din after capture SHALL NOT affect the word being transmitted.
REQ-022 load_ready, out, out_valid, last SHALL be decoded from registered state only (no combinational path from load_valid or din).

Reset
REQ-023 While reset=0: state=IDLE, shift register=0, counter=0, out=0, out_valid=0, last=0, load_ready=1; load_valid ignored.
REQ-024 reset asserted mid-word SHALL abort the word immediately (out and out_valid drop to 0 without waiting for clk); no remaining bits are sent after release.
REQ-025 After reset release the first rising edge SHALL behave as a normal IDLE cycle (load accepted if load_valid=1).

Verification (WIDTH=4, 100 ns clock period unless stated)
REQ-026 reset=0 for 100 ns, load_valid=0 -> out=0, out_valid=0, last=0, load_ready=1 throughout; remain IDLE after release.
REQ-027 Single load din=4'b1001, MSB_FIRST=1 -> out=1,0,0,1 on 4 consecutive cycles, out_valid=1 for those 4 only, last=1 on 4th, load_ready=0,0,0,1, then IDLE.
REQ-028 load_valid held with din=4'b1010 then 4'b0110 at the last-bit edge -> 8 contiguous bits 1,0,1,0,0,1,1,0, out_valid never drops, last=1 on bits 4 and 8.
REQ-029 During transmission of 4'b1001, load_valid=1 with din=4'b1111 in bit-2 cycle only -> ignored; output remains 1,0,0,1, then IDLE.
REQ-030 reset=0 asserted 30 ns after the edge presenting bit 2 of 4'b1100 -> out=0, out_valid=0 immediately; after release load 4'b0011 -> 0,0,1,1 with no remnant bits.
REQ-031 MSB_FIRST=0, load din=4'b1101 -> out=1,0,1,1, last=1 on 4th bit.
